weight_load_ctrl: RTL and testbench

- Sequencer that loads kernel weights from an upstream valid/ready stream into NUM_PE weight buffers and then triggers synchronized read bursts across all of them.
- Sits between the weight DMA stream and the PE array's weight buffers.
- Stages one kernel's worth of words locally, so every buffer flush sees back-to-back data with no bubbles.
- Runs num_pass broadcast read rounds per load.

---
 rtl/weight_load_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_weight_load_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : weight_load_ctrl
// Purpose  : Loads one kernel of weights at a time from a valid/ready stream
//            into a local staging store, then flushes and rewrites each of
//            NUM_PE weight buffers in turn. Once every buffer is loaded, it
//            issues num_pass broadcast read bursts. Each burst waits for all
//            buffers to report read-valid, then for all of them to go idle.
// Ports    : clk, rstn            - clock, async active-low reset
//            start_i              - job launch pulse (sampled in IDLE only)
//            kernel_size_i        - words per buffer (1..BUFFER_DEPTH)
//            num_pass_i           - read rounds after load (0 = load only)
//            w_data_i/w_valid_i/w_ready_o - upstream weight stream
//            buf_flush_o          - one-hot flush pulse to selected buffer
//            buf_data_o           - write data broadcast to all buffers
//            buf_flush_busy_i     - per-buffer flush busy status
//            buf_en_o             - broadcast read-start pulse
//            buf_read_valid_i     - per-buffer read-valid
//            busy_o/done_o/err_o  - job status
// Revision : 1.0 - initial release
// ============================================================================
module weight_load_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int BUFFER_DEPTH = 16,
  parameter int NUM_PE       = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [7:0]            kernel_size_i,
  input  logic [15:0]           num_pass_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  output logic [NUM_PE-1:0]     buf_flush_o,
  output logic [DATA_WIDTH-1:0] buf_data_o,
  input  logic [NUM_PE-1:0]     buf_flush_busy_i,
  output logic                  buf_en_o,
  input  logic [NUM_PE-1:0]     buf_read_valid_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int IDX_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam logic [NUM_PE-1:0] PE_ONE  = NUM_PE'(1);
  localparam logic [PE_W-1:0]   PE_LAST = PE_W'(NUM_PE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_FLUSH   = 3'd2,
    S_PUSH    = 3'd3,
    S_NEXT    = 3'd4,
    S_READ    = 3'd5,
    S_WAIT_RD = 3'd6,
    S_DONE    = 3'd7
  } state_e;

  state_e                state_q;
  logic [7:0]            k_q;
  logic [15:0]           p_q;
  logic [7:0]            fill_cnt_q;
  logic [7:0]            push_cnt_q;
  logic [PE_W-1:0]       pe_idx_q;
  logic [15:0]           pass_cnt_q;
  logic                  seen_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] stage_q [BUFFER_DEPTH];

  logic start_legal;
  logic flush_go;

  assign start_legal = (kernel_size_i != 8'd0) && ({24'd0, kernel_size_i} <= BUFFER_DEPTH);
  // The selected buffer must be idle before it is flushed; otherwise FLUSH stalls.
  assign flush_go    = (state_q == S_FLUSH) && !buf_flush_busy_i[pe_idx_q];

  // Outputs are decoded from the registered state; only the flush strobe
  // is qualified by the buffer's busy status in the same cycle.
  assign w_ready_o   = (state_q == S_FILL);
  assign buf_flush_o = flush_go ? (PE_ONE << pe_idx_q) : '0;
  assign buf_data_o  = (state_q == S_PUSH) ? stage_q[push_cnt_q[IDX_W-1:0]] : '0;
  assign buf_en_o    = (state_q == S_READ);
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;

  // Staging store: contents are don't-care out of reset, so no reset here.
  always_ff @(posedge clk) begin
    if ((state_q == S_FILL) && w_valid_i) begin
      stage_q[fill_cnt_q[IDX_W-1:0]] <= w_data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      p_q        <= '0;
      fill_cnt_q <= '0;
      push_cnt_q <= '0;
      pe_idx_q   <= '0;
      pass_cnt_q <= '0;
      seen_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (start_legal) begin
              k_q        <= kernel_size_i;
              p_q        <= num_pass_i;
              pe_idx_q   <= '0;
              pass_cnt_q <= '0;
              fill_cnt_q <= '0;
              push_cnt_q <= '0;
              seen_q     <= 1'b0;
              state_q    <= S_FILL;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_valid_i) begin
            if (fill_cnt_q == k_q - 8'd1) begin
              fill_cnt_q <= '0;
              state_q    <= S_FLUSH;
            end else begin
              fill_cnt_q <= fill_cnt_q + 8'd1;
            end
          end
        end
        S_FLUSH: begin
          if (flush_go) begin
            state_q <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (push_cnt_q == k_q - 8'd1) begin
            push_cnt_q <= '0;
            state_q    <= S_NEXT;
          end else begin
            push_cnt_q <= push_cnt_q + 8'd1;
          end
        end
        S_NEXT: begin
          if (pe_idx_q == PE_LAST) begin
            pe_idx_q <= '0;
            state_q  <= (p_q == 16'd0) ? S_DONE : S_READ;
          end else begin
            pe_idx_q <= pe_idx_q + PE_W'(1);
            state_q  <= S_FILL;
          end
        end
        S_READ: begin
          state_q <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          // A burst is complete only after every buffer has asserted
          // read-valid and then every buffer has released it.
          if (!seen_q) begin
            if (&buf_read_valid_i) begin
              seen_q <= 1'b1;
            end
          end else if (!(|buf_read_valid_i)) begin
            seen_q     <= 1'b0;
            pass_cnt_q <= pass_cnt_q + 16'd1;
            state_q    <= (pass_cnt_q + 16'd1 == p_q) ? S_DONE : S_READ;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_load_ctrl
// Purpose  : Self-checking bench for weight_load_ctrl. A table of job
//            configurations with hand-computed latencies and counts is run
//            through a cycle-level driver. The driver includes a simple
//            buffer read-valid model and a scoreboard for the pushed words.
//            Hand-written sequences cover reset, stray start and mid-job reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_load_ctrl;
  localparam int DW  = 16;
  localparam int BD  = 16;
  localparam int NPE = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [7:0]      ksize;
  logic [15:0]     npass;
  logic [DW-1:0]   wdata;
  logic            wvalid;
  logic            wready;
  logic [NPE-1:0]  bflush;
  logic [DW-1:0]   bdata;
  logic [NPE-1:0]  bfbusy;
  logic            ben;
  logic [NPE-1:0]  brv;
  logic            busy;
  logic            done;
  logic            err;

  always #5 clk = ~clk;

  weight_load_ctrl #(.DATA_WIDTH(DW), .BUFFER_DEPTH(BD), .NUM_PE(NPE)) dut (
    .clk(clk), .rstn(rstn), .start_i(start), .kernel_size_i(ksize),
    .num_pass_i(npass), .w_data_i(wdata), .w_valid_i(wvalid), .w_ready_o(wready),
    .buf_flush_o(bflush), .buf_data_o(bdata), .buf_flush_busy_i(bfbusy),
    .buf_en_o(ben), .buf_read_valid_i(brv), .busy_o(busy), .done_o(done),
    .err_o(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " w_ready"}, 64'(wready), 64'd0);
    check({tag, " buf_flush"}, 64'(bflush), 64'd0);
    check({tag, " buf_data"}, 64'(bdata), 64'd0);
    check({tag, " buf_en"}, 64'(ben), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " err"}, 64'(err), 64'd0);
  endtask

  // One job per record. lat = cycle offset of done relative to the start
  // cycle; f1 = offset of the second flush pulse (PE1).
  typedef struct {
    int k;
    int p;
    bit stall;
    int hold_pe;
    int hold_at;
    int hold_len;
    bit legal;
    int lat;
    int f1;
  } vec_t;

  vec_t vecs[9];

  task automatic run_job(input vec_t v, input int row);
    int nflush = 0, nen = 0, nbeats = 0, nerr = 0, errof = -1, nbusy = 0;
    int nwr = 0, ndone = 0, doneof = -1, f1of = -1, dbad = 0, enbad = 0;
    int ordbad = 0, pend = 0, en_cyc = -100, budget;
    logic [DW-1:0] word = 16'h0011;
    logic [DW-1:0] e;
    logic [DW-1:0] q[$];
    string t;
    t = $sformatf("row%0d", row);
    budget = v.legal ? 400 : 6;
    for (int off = 0; off < budget; off++) begin
      @(negedge clk);
      start  = (off == 0);
      ksize  = v.k[7:0];
      npass  = v.p[15:0];
      wvalid = v.stall ? (off % 2 == 0) : 1'b1;
      wdata  = word;
      bfbusy = (off >= v.hold_at && off < v.hold_at + v.hold_len) ? (NPE'(1) << v.hold_pe) : '0;
      // Buffer i holds read-valid from 2 cycles after en for k+i cycles.
      for (int i = 0; i < NPE; i++) brv[i] = (off >= en_cyc + 2) && (off <= en_cyc + 1 + v.k + i);
      #1;
      if (wvalid && wready) begin
        q.push_back(word);
        word = word + 16'd1;
        nbeats++;
      end
      if (busy) nbusy++;
      if (wready) nwr++;
      if (err) begin
        nerr++;
        if (errof < 0) errof = off;
      end
      if (pend > 0) begin
        pend--;
        if (q.size() == 0) dbad++;
        else begin
          e = q.pop_front();
          if (bdata !== e) dbad++;
        end
      end else if (bdata !== '0) dbad++;
      if (bflush !== '0) begin
        if (bflush !== (NPE'(1) << (nflush % NPE))) ordbad++;
        if (nflush == 1) f1of = off;
        nflush++;
        pend = v.k;
      end
      if (ben) begin
        nen++;
        if (|brv) enbad++;
        en_cyc = off;
      end
      if (done) begin
        ndone++;
        doneof = off;
        break;
      end
    end
    start = 1'b0; wvalid = 1'b0; bfbusy = '0; brv = '0;
    if (v.legal) begin
      check({t, " done offset"}, 64'(doneof), 64'(v.lat));
      check({t, " done count"}, 64'(ndone), 64'd1);
      check({t, " busy cycles"}, 64'(nbusy), 64'(v.lat - 1));
      check({t, " flush count"}, 64'(nflush), 64'(NPE));
      check({t, " flush order"}, 64'(ordbad), 64'd0);
      check({t, " PE1 flush offset"}, 64'(f1of), 64'(v.f1));
      check({t, " beats"}, 64'(nbeats), 64'(NPE * v.k));
      check({t, " push data"}, 64'(dbad), 64'd0);
      check({t, " en count"}, 64'(nen), 64'(v.p));
      check({t, " en during read"}, 64'(enbad), 64'd0);
      check({t, " err count"}, 64'(nerr), 64'd0);
    end else begin
      check({t, " err count"}, 64'(nerr), 64'd1);
      check({t, " err offset"}, 64'(errof), 64'd1);
      check({t, " busy cycles"}, 64'(nbusy), 64'd0);
      check({t, " w_ready cycles"}, 64'(nwr), 64'd0);
      check({t, " flush count"}, 64'(nflush), 64'd0);
      check({t, " done count"}, 64'(ndone), 64'd0);
    end
  endtask

  initial begin
    //          k    p  stall hpe hat hlen legal lat  f1
    vecs[0] = '{3,   1, 1'b0, 0,  0,  0,   1'b1, 42,  12};
    vecs[1] = '{4,   0, 1'b1, 0,  0,  0,   1'b1, 57,  23};
    vecs[2] = '{0,   0, 1'b0, 0,  0,  0,   1'b0, 0,   0};
    vecs[3] = '{17,  1, 1'b0, 0,  0,  0,   1'b0, 0,   0};
    vecs[4] = '{2,   3, 1'b0, 0,  0,  0,   1'b1, 49,  9};
    vecs[5] = '{3,   0, 1'b0, 1,  12, 5,   1'b1, 38,  17};
    vecs[6] = '{16,  1, 1'b0, 0,  0,  0,   1'b1, 159, 51};
    vecs[7] = '{1,   2, 1'b0, 0,  0,  0,   1'b1, 31,  6};
    vecs[8] = '{255, 0, 1'b0, 0,  0,  0,   1'b0, 0,   0};

    rstn = 1'b0; start = 1'b0; ksize = '0; npass = '0; wdata = '0;
    wvalid = 1'b0; bfbusy = '0; brv = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1 check_idle_outputs("in reset");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1 check_idle_outputs("after reset");

    // Stray starts during FILL/FLUSH, then reset in the middle of PUSH.
    @(negedge clk); start = 1'b1; ksize = 8'd3; npass = 16'd0; wvalid = 1'b1; wdata = 16'h00A1;
    @(negedge clk); start = 1'b0;
    #1 check("stray busy in FILL", 64'(busy), 64'd1);
    check("stray w_ready in FILL", 64'(wready), 64'd1);
    @(negedge clk); wdata = 16'h00A2; start = 1'b1; ksize = 8'd0;
    @(negedge clk); wdata = 16'h00A3; start = 1'b0; ksize = 8'd3;
    #1 check("stray start err", 64'(err), 64'd0);
    check("stray start busy", 64'(busy), 64'd1);
    @(negedge clk); wvalid = 1'b0; start = 1'b1;
    #1 check("stray first flush", 64'(bflush), 64'h1);
    @(negedge clk); start = 1'b0;
    #1 check("stray push word0", 64'(bdata), 64'h00A1);
    @(negedge clk);
    #1 check("stray push word1", 64'(bdata), 64'h00A2);
    #1 rstn = 1'b0;
    #1 check_idle_outputs("async reset mid-push");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1 check_idle_outputs("after mid-job reset");

    // Table-driven jobs; row 0 is also the job that must complete after reset.
    for (int r = 0; r < 9; r++) begin
      run_job(vecs[r], r);
    end

    @(negedge clk);
    #1 check("final idle busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
